// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Round-robin front end that shares one single-command SDRAM controller
//   among NumPorts requesters. A grant latches the winner's command, holds
//   the controller request line until accept, waits for the matching
//   completion strobe, then returns a one-cycle ack (plus read data).
//   A watchdog forces completion with an error if the controller stalls.
//
// Ports
//   i_dram_clk, i_rst        clock, async active-high reset
//   i_req/i_we               per-port request level and direction (1=write)
//   i_addr/i_wdata           per-port command, port k at [k*W +: W]
//   o_ack                    one-hot one-cycle completion pulse
//   o_rdata                  read data, valid with o_ack for reads
//   o_err                    pulses with o_ack on a watchdog completion
//   o_timeout_err            sticky watchdog flag, cleared only by reset
//   o_ctrl_*                 registered command to the controller
//   i_ctrl_*                 controller handshake / completion / read data
module sdram_port_arbiter #(
  parameter int NumPorts      = 4,
  parameter int AddrWidth     = 22,
  parameter int DataWidth     = 16,
  parameter int TimeoutCycles = 64
) (
  input  logic                           i_dram_clk,
  input  logic                           i_rst,
  input  logic [NumPorts-1:0]            i_req,
  input  logic [NumPorts-1:0]            i_we,
  input  logic [NumPorts*AddrWidth-1:0]  i_addr,
  input  logic [NumPorts*DataWidth-1:0]  i_wdata,
  output logic [NumPorts-1:0]            o_ack,
  output logic [DataWidth-1:0]           o_rdata,
  output logic                           o_err,
  output logic                           o_timeout_err,
  output logic                           o_ctrl_wr_req,
  output logic                           o_ctrl_rd_req,
  output logic [AddrWidth-1:0]           o_ctrl_addr,
  output logic [DataWidth-1:0]           o_ctrl_wr_data,
  input  logic                           i_ctrl_accept,
  input  logic                           i_ctrl_wr_done,
  input  logic                           i_ctrl_rd_rdy,
  input  logic [DataWidth-1:0]           i_ctrl_rd_data
);

  localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  // One extra bit so the counter can step past the limit when an accept
  // lands on the last ISSUE cycle.
  localparam int CW = $clog2(TimeoutCycles + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic          we_q;
  logic [CW-1:0] cnt;
  logic          timed_out;

  logic [NumPorts-1:0][AddrWidth-1:0] addr_arr;
  logic [NumPorts-1:0][DataWidth-1:0] wdata_arr;

  assign addr_arr  = i_addr;
  assign wdata_arr = i_wdata;
  assign timed_out = (cnt >= CW'(TimeoutCycles - 1));

  // First requester at or after ptr, with wrap. Scanning from the far end
  // down lets the nearest hit overwrite the others.
  logic          pick_vld;
  logic [PW-1:0] pick_idx;

  always_comb begin : arb_pick
    int j;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NumPorts;
      if (i_req[j]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(j);
      end
    end
  end

  always_ff @(posedge i_dram_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      gnt            <= '0;
      we_q           <= 1'b0;
      cnt            <= '0;
      o_ack          <= '0;
      o_rdata        <= '0;
      o_err          <= 1'b0;
      o_timeout_err  <= 1'b0;
      o_ctrl_wr_req  <= 1'b0;
      o_ctrl_rd_req  <= 1'b0;
      o_ctrl_addr    <= '0;
      o_ctrl_wr_data <= '0;
    end else begin
      o_ack <= '0;
      o_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt            <= pick_idx;
            we_q           <= i_we[pick_idx];
            o_ctrl_addr    <= addr_arr[pick_idx];
            o_ctrl_wr_data <= wdata_arr[pick_idx];
            o_ctrl_wr_req  <= i_we[pick_idx];
            o_ctrl_rd_req  <= ~i_we[pick_idx];
            cnt            <= '0;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Accept wins over the watchdog on the same cycle.
          if (i_ctrl_accept) begin
            o_ctrl_wr_req <= 1'b0;
            o_ctrl_rd_req <= 1'b0;
            cnt           <= cnt + CW'(1);
            state         <= S_WAIT;
          end else if (timed_out) begin
            o_ctrl_wr_req <= 1'b0;
            o_ctrl_rd_req <= 1'b0;
            o_ack         <= NumPorts'(1) << gnt;
            o_err         <= 1'b1;
            o_rdata       <= '0;
            o_timeout_err <= 1'b1;
            state         <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          // Only the strobe matching the latched direction completes.
          if (we_q && i_ctrl_wr_done) begin
            o_ack <= NumPorts'(1) << gnt;
            state <= S_RESP;
          end else if (!we_q && i_ctrl_rd_rdy) begin
            o_ack   <= NumPorts'(1) << gnt;
            o_rdata <= i_ctrl_rd_data;
            state   <= S_RESP;
          end else if (timed_out) begin
            o_ack         <= NumPorts'(1) << gnt;
            o_err         <= 1'b1;
            o_rdata       <= '0;
            o_timeout_err <= 1'b1;
            state         <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          // Just-served port drops to lowest priority.
          ptr   <= (gnt == PW'(NumPorts - 1)) ? '0 : gnt + PW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req, we;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata;
  logic [NP-1:0]     ack;
  logic [DW-1:0]     rdata;
  logic              err, terr, wr_req, rd_req;
  logic [AW-1:0]     c_addr;
  logic [DW-1:0]     c_wdata;
  logic              acc, wdone, rrdy;
  logic [DW-1:0]     rdin;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .i_dram_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(ack), .o_rdata(rdata), .o_err(err), .o_timeout_err(terr),
    .o_ctrl_wr_req(wr_req), .o_ctrl_rd_req(rd_req), .o_ctrl_addr(c_addr), .o_ctrl_wr_data(c_wdata),
    .i_ctrl_accept(acc), .i_ctrl_wr_done(wdone), .i_ctrl_rd_rdy(rrdy), .i_ctrl_rd_data(rdin)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  req;
    logic        acc;
    logic        wdone;
    logic        rrdy;
    logic [15:0] rdin;
    logic [3:0]  e_ack;
    logic        e_wr;
    logic        e_rd;
    logic        e_err;
    logic        chk_d;
    logic [15:0] e_rdata;
    logic        chk_a;
    logic [21:0] e_addr;
    logic [15:0] e_wdata;
  } vec_t;

  vec_t tbl [12];

  int gq[$];
  int cq[$];
  int n;

  initial begin
    // req acc wdone rrdy rdin | ack wr rd err | chk_d rdata | chk_a addr wdata
    // Port 2 write: accept on 2nd ISSUE cycle, done 3 cycles later, stray strobes.
    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 16'h0,    4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 22'h12345, 16'hBEEF};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 16'h0,    4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 22'h12345, 16'hBEEF};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 16'h0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 22'h0,     16'h0};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 22'h0,     16'h0};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 16'h0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 22'h0,     16'h0};
    tbl[5]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 16'h0,    4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 22'h0,     16'h0};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 16'h0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 22'h0,     16'h0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 16'h0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 22'h0,     16'h0};
    // Port 1 read: immediate accept, data 0xA5A5.
    tbl[8]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 16'h0,    4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 22'h00777, 16'h1111};
    tbl[9]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 16'h0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 22'h0,     16'h0};
    tbl[10] = '{4'b0010, 1'b0, 1'b0, 1'b1, 16'hA5A5, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b0, 22'h0,     16'h0};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 1'b0, 16'h0,    4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 22'h0,     16'h0};

    addr  = {22'h2ABCD, 22'h12345, 22'h00777, 22'h3C0F0};
    wdata = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    we    = 4'b0100;
    req = '0; acc = 1'b0; wdone = 1'b0; rrdy = 1'b0; rdin = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ack, err, terr, wr_req, rd_req, rdata, c_addr, c_wdata}, '0);
    @(negedge clk) rst = 1'b0;

    // ---- table-driven write / read traces ----
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req = tbl[i].req; acc = tbl[i].acc; wdone = tbl[i].wdone;
      rrdy = tbl[i].rrdy; rdin = tbl[i].rdin;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ctl", i), {ack, wr_req, rd_req, err, terr},
          {tbl[i].e_ack, tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_err, 1'b0});
      if (tbl[i].chk_d) chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
      if (tbl[i].chk_a) chk($sformatf("vec%0d_cmd", i), {c_addr, c_wdata}, {tbl[i].e_addr, tbl[i].e_wdata});
    end

    // ---- round robin from ptr=0 with immediate accept/done ----
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    req = 4'b1111; acc = 1'b1; wdone = 1'b1; rrdy = 1'b1; rdin = 16'h5A5A;
    for (int c = 1; c <= 26; c++) begin
      @(posedge clk);
      #1;
      if (ack != '0) begin
        chk($sformatf("rr_onehot_c%0d", c), $onehot(ack), 1'b1);
        for (int k = 0; k < NP; k++) if (ack[k]) gq.push_back(k);
        cq.push_back(c);
      end
    end
    chk("rr_ack_count", gq.size(), 6);
    if (gq.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk($sformatf("rr_grant%0d", k), gq[k], k % NP);
      chk("rr_first_ack_cycle", cq[0], 3);
      chk("rr_spacing_p0", cq[4] - cq[0], 16);
      chk("rr_spacing_p1", cq[5] - cq[1], 16);
    end
    @(negedge clk) req = '0;
    repeat (6) @(posedge clk);
    @(negedge clk) begin acc = 1'b0; wdone = 1'b0; rrdy = 1'b0; end
    chk("rr_last_rdata", rdata, 16'h5A5A);

    // ---- watchdog: port 3 read accepted, never completed ----
    @(negedge clk) req = 4'b1000;
    @(posedge clk);
    #1;
    chk("to_rd_req", {rd_req, c_addr}, {1'b1, 22'h2ABCD});
    n = 0;
    @(negedge clk) begin req = '0; acc = 1'b1; end
    @(posedge clk);
    #1;
    n = 1;
    chk("to_req_drop", rd_req, 1'b0);
    @(negedge clk) acc = 1'b0;
    while (ack == '0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("to_latency", n, 64);
    chk("to_resp", {ack, err, terr, rdata}, {4'b1000, 1'b1, 1'b1, 16'h0});
    repeat (5) @(posedge clk);
    #1;
    chk("to_sticky", {ack, err, terr}, {4'b0000, 1'b0, 1'b1});

    // ---- async reset mid-WAIT ----
    @(negedge clk) req = 4'b0001;
    @(negedge clk) begin req = '0; acc = 1'b1; end
    @(negedge clk) acc = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs", {ack, err, terr, wr_req, rd_req, rdata, c_addr, c_wdata}, '0);
    rrdy = 1'b1; rdin = 16'hDEAD;
    @(posedge clk);
    #1;
    chk("rst_no_ack", {ack, rdata}, '0);
    @(negedge clk) begin rst = 1'b0; rrdy = 1'b0; req = 4'b0010; end
    @(posedge clk);
    #1;
    chk("post_rst_grant_p1", {rd_req, c_addr}, {1'b1, 22'h00777});
    @(negedge clk) begin req = '0; acc = 1'b1; end
    @(negedge clk) begin acc = 1'b0; rrdy = 1'b1; rdin = 16'h0F0F; end
    @(posedge clk);
    #1;
    chk("post_rst_ack_p1", {ack, rdata, err}, {4'b0010, 16'h0F0F, 1'b0});
    @(negedge clk) begin rrdy = 1'b0; rst = 1'b1; end
    @(negedge clk) begin rst = 1'b0; req = 4'b1111; end
    @(posedge clk);
    #1;
    chk("post_rst_grant_p0", {rd_req, c_addr}, {1'b1, 22'h3C0F0});
    @(negedge clk) begin req = '0; acc = 1'b1; end
    @(negedge clk) begin acc = 1'b0; rrdy = 1'b1; rdin = 16'h7777; end
    @(posedge clk);
    #1;
    chk("post_rst_ack_p0", {ack, rdata}, {4'b0001, 16'h7777});
    @(negedge clk) rrdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
